keypad_scanner: RTL

- Scans a 4x3 matrix keypad and debounces it, producing the 4-bit `key` code consumed by the alarm-clock control FSM.
- `key` is a level:
  - the digit 0-9 while a digit key is held stably;
  - NOKEY (10) otherwise.
- Sits directly upstream of the control FSM's `key` input.
- Keys * and # are not digits and report NOKEY.

---
 rtl/keypad_scanner_pkg.sv | 32 +++
 rtl/keypad_scanner_key_debounce.sv | 110 +++++++++++
 rtl/keypad_scanner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared constants, debounce states and key map for the keypad scanner
//
// Purpose: constants, debounce state encoding and the row/column to key
// code map shared by keypad_scanner and key_debounce.
// Ports: none (package).
package keypad_scanner_pkg;

  localparam logic [3:0] NOKEY    = 4'd10;
  localparam int         NUM_COLS = 3;
  localparam int         NUM_ROWS = 4;

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    PRESS_CHECK   = 2'd1,
    PRESSED       = 2'd2,
    RELEASE_CHECK = 2'd3
  } deb_state_t;

  // Rows 0-2 hold digits 1-9 left to right; row 3 is "* 0 #", where
  // * and # are not digits and report NOKEY.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = NOKEY;
    if (r == 2'd3) begin
      if (c == 2'd1) code = 4'd0;
    end else if (c <= 2'd2) begin
      code = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_key_debounce.sv
// rtl/keypad_scanner_key_debounce.sv - frame-based press/release debounce of the scanned key code
//
// Purpose: turns the per-frame key code into a stable key level. A digit
// must be seen in DEBOUNCE consecutive frames to be reported; a reported
// digit must be absent for DEBOUNCE consecutive frames to be released.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   frame_done     one-cycle strobe, frame_code valid
//   frame_code     digit seen this frame, or NOKEY
//   key            debounced digit or NOKEY (registered)
//   key_event      one-cycle pulse on NOKEY -> digit (registered)
module key_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_done,
  input  logic [3:0] frame_code,
  output logic [3:0] key,
  output logic       key_event
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  deb_state_t       state, state_n;
  logic [CNT_W-1:0] count, count_n, count_inc;
  logic [3:0]       candidate, candidate_n;
  logic [3:0]       key_n;
  logic             key_event_n;
  logic             at_limit;

  assign count_inc = count + 1'b1;
  assign at_limit  = (count_inc == CNT_W'(DEBOUNCE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RELEASED;
      count     <= '0;
      candidate <= NOKEY;
      key       <= NOKEY;
      key_event <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      candidate <= candidate_n;
      key       <= key_n;
      key_event <= key_event_n;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    candidate_n = candidate;
    key_n       = key;
    key_event_n = 1'b0;
    if (frame_done) begin
      unique case (state)
        RELEASED: begin
          if (frame_code != NOKEY) begin
            state_n     = PRESS_CHECK;
            candidate_n = frame_code;
            count_n     = CNT_W'(1);
          end
        end
        PRESS_CHECK: begin
          if (frame_code == candidate) begin
            count_n = count_inc;
            if (at_limit) begin
              state_n     = PRESSED;
              key_n       = candidate;
              key_event_n = 1'b1;
              count_n     = '0;
            end
          end else begin
            // A different digit restarts from RELEASED rather than being
            // adopted, so every candidate gets a full run of its own.
            state_n = RELEASED;
            count_n = '0;
          end
        end
        PRESSED: begin
          if (frame_code != key) begin
            state_n = RELEASE_CHECK;
            count_n = CNT_W'(1);
          end
        end
        RELEASE_CHECK: begin
          if (frame_code == key) begin
            state_n = PRESSED;
            count_n = '0;
          end else begin
            count_n = count_inc;
            if (at_limit) begin
              // Always drop to NOKEY first so downstream sees a release
              // between two different digits.
              state_n = RELEASED;
              key_n   = NOKEY;
              count_n = '0;
            end
          end
        end
        default: state_n = RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad scanner with row sync, column drive and debounce
//
// Purpose: drives the keypad columns one at a time, samples the
// synchronized rows at the end of each column slot, reduces a full frame
// to a single key code (rejecting multi-press) and debounces it.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   row[3:0]       keypad rows, active-low, asynchronous
//   col[2:0]       column drive, active-low, one-hot-low
//   key[3:0]       debounced digit 0-9 or NOKEY
//   key_event      one-cycle pulse on NOKEY -> digit
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       key_event
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [3:0]       sync1, sync2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [1:0]       acc_count;
  logic [3:0]       acc_code;

  logic             sample;
  logic             frame_done;
  logic [2:0]       col_hits;
  logic [3:0]       col_code;
  logic [3:0]       hit_sum;
  logic [1:0]       sat_count;
  logic [3:0]       sum_code;
  logic [3:0]       frame_code;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= row;
      sync2 <= sync1;
    end
  end

  assign sample     = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_done = sample && (col_idx == 2'd2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div     <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      div     <= '0;
      col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_comb begin
    col = 3'b111;
    unique case (col_idx)
      2'd0:    col = 3'b110;
      2'd1:    col = 3'b101;
      2'd2:    col = 3'b011;
      default: col = 3'b111;
    endcase
  end

  // Rows pressed in the current column. The stored code is only used
  // when exactly one key was seen in the whole frame.
  always_comb begin
    col_hits = 3'd0;
    col_code = NOKEY;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!sync2[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_code(2'(r), col_idx);
      end
    end
  end

  // Frame totals including the current sample; the hit count saturates
  // at 2 because only "none", "one" and "several" matter. * and # count
  // as hits but carry NOKEY, so they also block a lone digit.
  always_comb begin
    hit_sum    = {2'b00, acc_count} + {1'b0, col_hits};
    sat_count  = (hit_sum >= 4'd2) ? 2'd2 : hit_sum[1:0];
    sum_code   = (acc_count != 2'd0) ? acc_code : col_code;
    frame_code = (sat_count == 2'd1) ? sum_code : NOKEY;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_count <= 2'd0;
      acc_code  <= NOKEY;
    end else if (frame_done) begin
      acc_count <= 2'd0;
      acc_code  <= NOKEY;
    end else if (sample) begin
      acc_count <= sat_count;
      acc_code  <= sum_code;
    end
  end

  key_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clock     (clock),
    .reset     (reset),
    .frame_done(frame_done),
    .frame_code(frame_code),
    .key       (key),
    .key_event (key_event)
  );

endmodule
